// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and defaults for the UART TX arbiter
package uart_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_BEAT = 3'b010,
    S_HOLD = 3'b100
  } state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - round-robin first-valid picker starting after ptr_i
module rr_priority_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan ptr_i+1, ptr_i+2, ... mod N and take the first requester that is set.
  always_comb begin
    int   j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter onto the TX FIFO write port
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 16,
  parameter int HOLDOFF   = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  input  logic [N_REQ-1:0]          req_last_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          grant_o,
  input  logic                      tx_full_i,
  output logic                      wr_en_o,
  output logic [DATA_W-1:0]         wr_data_o,
  output logic                      busy_o
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic               last_q, last_d;
  logic               wr_en_q, wr_en_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;

  logic [N_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  owner_data;
  logic [7:0]         burst_inc;

  rr_priority_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign owner_data = req_data_i[int'(owner_q)*DATA_W +: DATA_W];
  assign burst_inc  = burst_cnt_q + 8'd1;

  assign grant_o   = grant_q;
  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (state_q != S_IDLE);

  // State and datapath registers; reset abandons any packet in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= IDX_W'(N_REQ - 1);
      burst_cnt_q <= '0;
      hold_cnt_q  <= '0;
      last_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Next-state: arbitrate only when idle, accept one byte per beat, then wait out the hold-off.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    req_ready_o = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_d     = pick_gnt;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = S_BEAT;
        end
      end
      S_BEAT: begin
        req_ready_o[owner_q] = !tx_full_i;
        if (req_valid_i[owner_q] && !tx_full_i) begin
          wr_en_d     = 1'b1;
          wr_data_d   = owner_data;
          burst_cnt_d = burst_inc;
          last_d      = req_last_i[owner_q] | (burst_inc == 8'(MAX_BURST));
          hold_cnt_d  = 8'(HOLDOFF - 1);
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == 8'd0) begin
          if (last_q) begin
            rr_ptr_d = owner_q;
            grant_d  = '0;
            state_d  = S_IDLE;
          end else begin
            state_d = S_BEAT;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int HO = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            tx_full = 1'b0;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic            busy;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic [8:0]   rq [N][$];
  bit   [N-1:0] pend = '0;
  logic [7:0]   log_d [$];
  int           log_c [$];
  logic [N-1:0] log_g [$];

  uart_tx_arbiter #(
    .N_REQ     (N),
    .DATA_W    (DW),
    .MAX_BURST (MB),
    .HOLDOFF   (HO)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .tx_full_i   (tx_full),
    .wr_en_o     (wr_en),
    .wr_data_o   (wr_data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Requester model: pop on last handshake, present queue head, note whether it handshakes next edge.
  always @(negedge clk) begin
    logic [8:0] h;
    for (int i = 0; i < N; i++)
      if (pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        h = rq[i][0];
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = h[7:0];
        req_last[i] = h[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = '0;
        req_last[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < N; i++) pend[i] = req_valid[i] & req_ready[i];
  end

  // FIFO-side monitor.
  always @(negedge clk) begin
    if (rstn && wr_en) begin
      log_d.push_back(wr_data);
      log_c.push_back(cyc);
      log_g.push_back(grant);
    end
  end

  task automatic clear_log();
    log_d.delete();
    log_c.delete();
    log_g.delete();
  endtask

  task automatic push(input int r, input logic [7:0] d, input bit last);
    rq[r].push_back({last, d});
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    int k = 0;
    while (log_d.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    #1;
    ok = (log_d.size() >= n);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    #2;
    for (int i = 0; i < N; i++) rq[i].delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #3;
    clear_log();
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #1;
    rstn = 1'b0;
    #1;
    n_total++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    n_total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else n_pass++;
    n_total++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", wr_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_packet();
    bit ok;
    int t0;
    logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
    @(posedge clk); #1;
    clear_log();
    t0 = cyc;
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
    wait_writes(3, 40, ok);
    n_total++; if (!ok) $display("FAIL single_timeout: got %0d writes want 3", log_d.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++; if (log_d[i] !== exp[i]) $display("FAIL single_data%0d: got %h want %h", i, log_d[i], exp[i]); else n_pass++;
      n_total++; if (log_g[i] !== 4'b0001) $display("FAIL single_grant%0d: got %b want 0001", i, log_g[i]); else n_pass++;
    end
    n_total++; if (log_c[0] !== t0 + 2) $display("FAIL single_latency: got cycle %0d want %0d", log_c[0], t0 + 2); else n_pass++;
    n_total++; if (log_c[1] - log_c[0] !== 3) $display("FAIL single_gap01: got %0d want 3", log_c[1] - log_c[0]); else n_pass++;
    n_total++; if (log_c[2] - log_c[1] !== 3) $display("FAIL single_gap12: got %0d want 3", log_c[2] - log_c[1]); else n_pass++;
    repeat (4) @(negedge clk);
    #1;
    n_total++; if (grant !== 4'b0000) $display("FAIL single_grant_end: got %b want 0000", grant); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] exp1 [4] = '{8'h10, 8'h11, 8'h20, 8'h21};
    logic [7:0] exp2 [4] = '{8'h30, 8'h31, 8'h40, 8'h41};
    apply_reset();
    @(posedge clk); #1;
    push(0, 8'h10, 0); push(0, 8'h11, 1);
    push(2, 8'h20, 0); push(2, 8'h21, 1);
    wait_writes(4, 60, ok);
    n_total++; if (!ok) $display("FAIL rr1_timeout: got %0d writes want 4", log_d.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (log_d[i] !== exp1[i]) $display("FAIL rr1_data%0d: got %h want %h", i, log_d[i], exp1[i]); else n_pass++;
    end
    clear_log();
    push(0, 8'h30, 0); push(0, 8'h31, 1);
    push(2, 8'h40, 0); push(2, 8'h41, 1);
    wait_writes(4, 60, ok);
    n_total++; if (!ok) $display("FAIL rr2_timeout: got %0d writes want 4", log_d.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (log_d[i] !== exp2[i]) $display("FAIL rr2_data%0d: got %h want %h", i, log_d[i], exp2[i]); else n_pass++;
    end
  endtask

  task automatic test_max_burst();
    bit ok;
    int k;
    logic [7:0] exp [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hA4, 8'hA5};
    apply_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) push(3, 8'hA0 + 8'(i), i == 5);
    k = 0;
    while (grant !== 4'b1000 && k < 10) begin @(negedge clk); #1; k++; end
    n_total++; if (grant !== 4'b1000) $display("FAIL burst_grant3: got %b want 1000", grant); else n_pass++;
    @(posedge clk); #1;
    push(1, 8'hB0, 0); push(1, 8'hB1, 1);
    wait_writes(8, 150, ok);
    n_total++; if (!ok) $display("FAIL burst_timeout: got %0d writes want 8", log_d.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++; if (log_d[i] !== exp[i]) $display("FAIL burst_data%0d: got %h want %h", i, log_d[i], exp[i]); else n_pass++;
    end
    n_total++; if (log_g[4] !== 4'b0010) $display("FAIL burst_grant_switch: got %b want 0010", log_g[4]); else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_full_stall();
    bit ok;
    bit bad = 0;
    int c;
    @(negedge clk);
    tx_full = 1'b1;
    @(posedge clk); #1;
    clear_log();
    push(1, 8'h55, 1);
    repeat (20) begin
      @(negedge clk); #2;
      if (req_ready !== 4'b0000 || wr_en !== 1'b0) bad = 1;
    end
    n_total++; if (bad) $display("FAIL full_stall: got ready or write while full want none"); else n_pass++;
    n_total++; if (grant !== 4'b0010) $display("FAIL full_grant: got %b want 0010", grant); else n_pass++;
    @(negedge clk);
    tx_full = 1'b0;
    c = cyc;
    wait_writes(1, 10, ok);
    n_total++; if (log_d[0] !== 8'h55) $display("FAIL full_data: got %h want 55", log_d[0]); else n_pass++;
    n_total++; if (!ok || log_c[0] - c < 1 || log_c[0] - c > 2) $display("FAIL full_release_latency: got %0d want 1..2", log_c[0] - c); else n_pass++;
    repeat (8) @(negedge clk);
    #1;
    n_total++; if (log_d.size() !== 1) $display("FAIL full_count: got %0d want 1", log_d.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k = 0;
    @(posedge clk); #1;
    clear_log();
    push(2, 8'h60, 0); push(2, 8'h61, 0); push(2, 8'h62, 1);
    @(negedge clk);
    while (wr_en !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_total++; if (wr_en !== 1'b1) $display("FAIL rstmid_first_write: got %b want 1", wr_en); else n_pass++;
    rstn = 1'b0;
    #1;
    n_total++; if (wr_en !== 1'b0) $display("FAIL rstmid_wr_en: got %b want 0", wr_en); else n_pass++;
    n_total++; if (grant !== 4'b0000) $display("FAIL rstmid_grant: got %b want 0000", grant); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (wr_data !== 8'h00) $display("FAIL rstmid_wr_data: got %h want 00", wr_data); else n_pass++;
    #1;
    for (int i = 0; i < N; i++) rq[i].delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #3;
    clear_log();
    repeat (5) @(negedge clk);
    #1;
    n_total++; if (log_d.size() !== 0) $display("FAIL rstmid_stale: got %0d writes want 0", log_d.size()); else n_pass++;
    @(posedge clk); #1;
    push(1, 8'h71, 1);
    push(0, 8'h70, 1);
    wait_writes(2, 40, ok);
    n_total++; if (log_d[0] !== 8'h70) $display("FAIL rstmid_prio0: got %h want 70", log_d[0]); else n_pass++;
    n_total++; if (log_d[1] !== 8'h71) $display("FAIL rstmid_prio1: got %h want 71", log_d[1]); else n_pass++;
    repeat (6) @(negedge clk);
    #1;
    n_total++; if (log_d.size() !== 2) $display("FAIL rstmid_count: got %0d want 2", log_d.size()); else n_pass++;
  endtask

  task automatic test_owner_gap();
    bit ok;
    bit bad = 0;
    logic [7:0] exp [4] = '{8'h80, 8'h81, 8'h82, 8'h90};
    @(posedge clk); #1;
    clear_log();
    push(1, 8'h80, 0);
    wait_writes(1, 20, ok);
    n_total++; if (!ok) $display("FAIL gap_first: got %0d writes want 1", log_d.size()); else n_pass++;
    @(posedge clk); #1;
    push(0, 8'h90, 1);
    repeat (10) begin
      @(negedge clk); #2;
      if (grant !== 4'b0010 || log_d.size() !== 1) bad = 1;
    end
    n_total++; if (bad) $display("FAIL gap_locked: got grant %b writes %0d want 0010 and 1", grant, log_d.size()); else n_pass++;
    @(posedge clk); #1;
    push(1, 8'h81, 0); push(1, 8'h82, 1);
    wait_writes(4, 60, ok);
    for (int i = 0; i < 4; i++) begin
      n_total++; if (log_d[i] !== exp[i]) $display("FAIL gap_data%0d: got %h want %h", i, log_d[i], exp[i]); else n_pass++;
    end
    n_total++; if (log_g[3] !== 4'b0001) $display("FAIL gap_grant_req0: got %b want 0001", log_g[3]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_max_burst();
    test_full_stall();
    test_reset_mid();
    test_owner_gap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single byte-write port of the UART transmit path (the TX FIFO write-enable, write-data and full-flag interface) among N_REQ independent byte-stream requesters. A requester's packet is locked to it until its last byte or until MAX_BURST bytes, so messages are not interleaved. Each write is followed by a hold-off so the FIFO full flag seen by the arbiter is always current, and no byte is silently dropped.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
MAX_BURST, 16, max bytes per grant before forced re-arbitration (1..255)
HOLDOFF, 2, cycles after each accepted byte before the next may be accepted (>=2, covers registered write-enable plus FIFO update)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
req_valid_i  in  N_REQ  per-requester byte valid
req_data_i  in  N_REQ*DATA_W  per-requester byte; requester i uses bits [i*DATA_W +: DATA_W]
req_last_i  in  N_REQ  byte is last of packet; qualified by valid & ready
req_ready_o  out  N_REQ  byte accepted this cycle (combinational)
grant_o  out  N_REQ  one-hot current owner (registered), 0 when idle
tx_full_i  in  1  TX FIFO full flag
wr_en_o  out  1  single-cycle FIFO write-enable pulse (registered)
wr_data_o  out  DATA_W  byte for FIFO (registered, valid with wr_en_o)
busy_o  out  1  high whenever state != S_IDLE

Behaviour:
- Reset (async, rstn_i low): state=S_IDLE, grant_o=0, wr_en_o=0, wr_data_o=0, burst_cnt=0, hold_cnt=0, rr_ptr=N_REQ-1 (requester 0 wins first). All requester handshakes abort; a partial packet is abandoned.
- States:
- S_IDLE: if any req_valid_i, the owner is the first valid index scanning rr_ptr+1, rr_ptr+2, ... mod N_REQ. Register grant_o, clear burst_cnt, go to S_BEAT. Otherwise stay.
- S_BEAT: req_ready_o[owner] = !tx_full_i; all other ready bits are 0. On req_valid_i[owner] & ready, the byte is accepted: next cycle wr_en_o=1 and wr_data_o=byte; burst_cnt++; last_flag <= req_last_i[owner] | (burst_cnt+1 == MAX_BURST). Go to S_HOLD with hold_cnt=HOLDOFF-1.
- S_BEAT, owner not valid: stay locked, ready high as above. Do not re-arbitrate mid-packet.
- S_BEAT, tx_full_i high: ready=0 and wait. The byte remains with the requester.
- S_HOLD: wr_en_o is high only in the first S_HOLD cycle. Decrement hold_cnt. At 0: if last_flag, set rr_ptr=owner, grant_o=0, go to S_IDLE. Otherwise go to S_BEAT.
- Outside S_BEAT, req_ready_o=0.
- Latency: valid in S_IDLE at cycle t → grant at t+1, ready at t+1 (if not full), wr_en_o at t+2.
- Throughput: one byte per HOLDOFF+1 cycles. wr_en_o is never high in two cycles closer than HOLDOFF+1 apart.
- Simultaneous requests: resolved only in S_IDLE by round-robin. A requester that has just finished has the lowest priority next round.
- MAX_BURST reached without last: the owner loses the grant and must re-win arbitration to continue.
- burst_cnt is 8 bits, never wraps (bounded by MAX_BURST).
- wr_en_o is never asserted for a byte that was not handshaked. A tx_full_i rise during S_HOLD has no effect until S_BEAT.

Decomposition:
- Shared package uart_pkg: state encodings (S_IDLE, S_BEAT, S_HOLD, one-hot 3 bits), DATA_W default.
- One combinational sub-module rr_priority_picker (inputs: request vector, rr_ptr; outputs: one-hot grant and index). It is reusable by the RX-side dispatcher.

Test Plan:
- Req0 sends 0x41,0x42,0x43 (last on 0x43), FIFO not full → wr_en_o pulses carry 0x41/0x42/0x43 exactly 3 cycles apart, grant_o=0001 throughout, then 0 and busy_o=0.
- Req0 and req2 both valid from reset with 2-byte packets {0x10,0x11} and {0x20,0x21} → FIFO sequence 0x10,0x11,0x20,0x21. Then req0 and req2 request again → req2 wins? No: rr_ptr=2, so req0 wins. Bytes are never interleaved.
- tx_full_i held high for 20 cycles while req1 is valid with 0x55 → ready stays 0 and wr_en_o stays 0. Release full → exactly one 0x55 write within 2 cycles.
- MAX_BURST=4, req3 streams 6 bytes without last while req1 waits → 4 bytes from req3, then req1's packet, then req3's remaining 2 bytes.
- rstn_i asserted during S_HOLD mid-packet → all outputs go to 0 immediately. After release, requester 0 has priority and no stale wr_en_o is issued.
- Req1 drops valid mid-packet for 10 cycles while req0 is valid → grant_o stays 0010 and there is no write from req0 until req1's last byte.
